// File: rtl/sub_arb_2req_8b_pkg.sv
// ----------------------------------------------------------------------------
// sub_arb_2req_8b_pkg
// Shared definitions for the two-requester arbitrated subtractor.
//   NBITS_DEFAULT : default operand / result width
//   state_t       : output-slot state (EMPTY = no result held, FULL = held)
// ----------------------------------------------------------------------------
package sub_arb_2req_8b_pkg;

   localparam int NBITS_DEFAULT = 8;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

endpackage : sub_arb_2req_8b_pkg

// File: rtl/sub_arb_2req_8b_sub_ovf_nb.sv
// ----------------------------------------------------------------------------
// sub_ovf_nb
// Purely combinational NBITS-wide subtractor with signed overflow flag.
//   in0, in1 : operands
//   diff     : (in0 - in1) mod 2^NBITS
//   ovf      : two's-complement overflow of in0 - in1
// ----------------------------------------------------------------------------
module sub_ovf_nb
   import sub_arb_2req_8b_pkg::*;
#(
   parameter int NBITS = NBITS_DEFAULT
) (
   input  logic [NBITS-1:0] in0,
   input  logic [NBITS-1:0] in1,
   output logic [NBITS-1:0] diff,
   output logic             ovf
);

   assign diff = in0 - in1;

   // Subtraction can only overflow when the operands have opposite signs;
   // it did overflow when the result's sign disagrees with the minuend.
   assign ovf = (in0[NBITS-1] != in1[NBITS-1]) && (diff[NBITS-1] != in0[NBITS-1]);

endmodule : sub_ovf_nb

// File: rtl/sub_arb_2req_8b.sv
// ----------------------------------------------------------------------------
// sub_arb_2req_8b
// Two requesters share one subtractor. A round-robin pointer picks between
// them when both are valid; the winner's difference is registered into a
// single-entry output slot (one-cycle latency, full throughput when the
// consumer is always ready).
//   clk, reset                    : clock, asynchronous active-low reset
//   req0_val/rdy/in0/in1          : requester 0 handshake and operands
//   req1_val/rdy/in0/in1          : requester 1 handshake and operands
//   resp_val/rdy                  : result handshake
//   resp_out, resp_ovf, resp_id   : difference, signed overflow, requester id
// ----------------------------------------------------------------------------
module sub_arb_2req_8b
   import sub_arb_2req_8b_pkg::*;
#(
   parameter int NBITS = NBITS_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,

   input  logic             req0_val,
   output logic             req0_rdy,
   input  logic [NBITS-1:0] req0_in0,
   input  logic [NBITS-1:0] req0_in1,

   input  logic             req1_val,
   output logic             req1_rdy,
   input  logic [NBITS-1:0] req1_in0,
   input  logic [NBITS-1:0] req1_in1,

   output logic             resp_val,
   input  logic             resp_rdy,
   output logic [NBITS-1:0] resp_out,
   output logic             resp_ovf,
   output logic             resp_id
);

   // State
   state_t           r_state;
   logic             r_prio;     // requester preferred when both are valid
   logic [NBITS-1:0] r_out;
   logic             r_ovf;
   logic             r_id;

   // Combinational
   logic             w_gnt0;
   logic             w_gnt1;
   logic             w_slot_free;
   logic             w_accept;
   logic             w_resp_xfer;
   logic [NBITS-1:0] w_op0;
   logic [NBITS-1:0] w_op1;
   logic [NBITS-1:0] w_diff;
   logic             w_ovf;

   // Grant: a lone valid requester always wins; a tie goes to r_prio.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path
      // through the case can leave a value unassigned and infer a latch.
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
      case ({req1_val, req0_val})
         2'b01:   w_gnt0 = 1'b1;
         2'b10:   w_gnt1 = 1'b1;
         2'b11: begin
            if (r_prio) w_gnt1 = 1'b1;
            else        w_gnt0 = 1'b1;
         end
         default: ;
      endcase
   end

   // The slot can take a new result if it is empty or its content leaves
   // this same cycle.
   assign w_slot_free = (r_state == ST_EMPTY) || resp_rdy;

   // Reset gating keeps both ready lines low while reset is asserted, even
   // though the slot then reads as EMPTY.
   assign req0_rdy = reset & w_slot_free & w_gnt0;
   assign req1_rdy = reset & w_slot_free & w_gnt1;

   // A ready line is only ever high together with its own valid.
   assign w_accept    = req0_rdy | req1_rdy;
   assign w_resp_xfer = resp_val & resp_rdy;

   // Operand mux follows the grant; the id of the winner is w_gnt1.
   assign w_op0 = w_gnt1 ? req1_in0 : req0_in0;
   assign w_op1 = w_gnt1 ? req1_in1 : req0_in1;

   sub_ovf_nb #(
      .NBITS (NBITS)
   ) u_sub (
      .in0  (w_op0),
      .in1  (w_op1),
      .diff (w_diff),
      .ovf  (w_ovf)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         // NOTE: the result registers are reset too, because the result
         // outputs must read zero while reset is held.
         r_state <= ST_EMPTY;
         r_prio  <= 1'b0;
         r_out   <= '0;
         r_ovf   <= 1'b0;
         r_id    <= 1'b0;
      end else if (w_accept) begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values, independent of statement order.
         r_state <= ST_FULL;
         r_out   <= w_diff;
         r_ovf   <= w_ovf;
         r_id    <= w_gnt1;
         r_prio  <= ~w_gnt1;   // the other requester wins the next tie
      end else if (w_resp_xfer) begin
         r_state <= ST_EMPTY;
      end
   end

   assign resp_val = (r_state == ST_FULL);
   assign resp_out = r_out;
   assign resp_ovf = r_ovf;
   assign resp_id  = r_id;

endmodule : sub_arb_2req_8b

// File: tb/tb_sub_arb_2req_8b.sv
// ----------------------------------------------------------------------------
// tb_sub_arb_2req_8b
// Self-checking bench for sub_arb_2req_8b. The reference model is a queue of
// pending results in grant order plus a round-robin pointer; results are
// computed with integer arithmetic (signed range test for overflow).
// ----------------------------------------------------------------------------
module tb_sub_arb_2req_8b;

   localparam int W = 8;

   typedef struct {
      logic [W-1:0] out;
      logic         ovf;
      logic         id;
   } res_t;

   logic         clk;
   logic         reset;
   logic         req0_val, req1_val;
   logic         req0_rdy, req1_rdy;
   logic [W-1:0] req0_in0, req0_in1, req1_in0, req1_in1;
   logic         resp_val, resp_rdy;
   logic [W-1:0] resp_out;
   logic         resp_ovf, resp_id;

   int   n_checks   = 0;
   int   n_errors   = 0;
   int   n_accepted = 0;
   int   n_drained  = 0;
   int   m_prio     = 0;
   res_t m_q[$];

   sub_arb_2req_8b #(.NBITS(W)) dut (
      .clk      (clk),
      .reset    (reset),
      .req0_val (req0_val),
      .req0_rdy (req0_rdy),
      .req0_in0 (req0_in0),
      .req0_in1 (req0_in1),
      .req1_val (req1_val),
      .req1_rdy (req1_rdy),
      .req1_in0 (req1_in0),
      .req1_in1 (req1_in1),
      .resp_val (resp_val),
      .resp_rdy (resp_rdy),
      .resp_out (resp_out),
      .resp_ovf (resp_ovf),
      .resp_id  (resp_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference result from plain signed arithmetic.
   function automatic res_t model_sub(input logic [W-1:0] a, input logic [W-1:0] b, input int id);
      res_t r;
      int   sa, sb, d;
      sa = int'($signed(a));
      sb = int'($signed(b));
      d  = sa - sb;
      r.out = W'(d);
      r.ovf = (d > 127) || (d < -128);
      r.id  = (id == 1);
      return r;
   endfunction

   // One clock cycle: drive inputs, check combinational and held outputs,
   // cross the edge, then advance the model. Entered and left at posedge+1.
   task automatic cycle(input bit v0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                        input bit v1, input logic [W-1:0] a1, input logic [W-1:0] b1,
                        input bit rr);
      int g;
      bit free;
      req0_val = v0; req0_in0 = a0; req0_in1 = b0;
      req1_val = v1; req1_in0 = a1; req1_in1 = b1;
      resp_rdy = rr;
      #1;
      free = (m_q.size() == 0) || rr;
      if (v0 && v1)  g = m_prio;
      else if (v0)   g = 0;
      else if (v1)   g = 1;
      else           g = -1;
      check("req0_rdy", 32'(req0_rdy), 32'(free && g == 0));
      check("req1_rdy", 32'(req1_rdy), 32'(free && g == 1));
      check("resp_val", 32'(resp_val), 32'(m_q.size() != 0));
      if (m_q.size() != 0) begin
         check("resp_out", 32'(resp_out), 32'(m_q[0].out));
         check("resp_ovf", 32'(resp_ovf), 32'(m_q[0].ovf));
         check("resp_id",  32'(resp_id),  32'(m_q[0].id));
      end
      @(posedge clk);
      #1;
      if (m_q.size() != 0 && rr) begin
         void'(m_q.pop_front());
         n_drained++;
      end
      if (free && g >= 0) begin
         m_q.push_back(g == 0 ? model_sub(a0, b0, 0) : model_sub(a1, b1, 1));
         m_prio = 1 - g;
         n_accepted++;
      end
   endtask

   // Assert reset away from a clock edge with current inputs left in place,
   // check the asynchronous reset values, then release before the next edge.
   task automatic do_reset();
      reset = 1'b0;
      #1;
      check("rst_resp_val", 32'(resp_val), 32'd0);
      check("rst_resp_out", 32'(resp_out), 32'd0);
      check("rst_resp_ovf", 32'(resp_ovf), 32'd0);
      check("rst_resp_id",  32'(resp_id),  32'd0);
      check("rst_req0_rdy", 32'(req0_rdy), 32'd0);
      check("rst_req1_rdy", 32'(req1_rdy), 32'd0);
      req0_val = 1'b0;
      req1_val = 1'b0;
      resp_rdy = 1'b0;
      m_q.delete();
      m_prio = 0;
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int acc0, drn0, budget;
      reset    = 1'b0;
      req0_val = 1'b0; req0_in0 = '0; req0_in1 = '0;
      req1_val = 1'b0; req1_in0 = '0; req1_in1 = '0;
      resp_rdy = 1'b0;
      @(posedge clk);
      #1;
      do_reset();

      // Single request from requester 0: 42 - 13 = 29.
      cycle(1, 8'd42, 8'd13, 0, 8'd0, 8'd0, 1);
      check("t1_val", 32'(resp_val), 32'd1);
      check("t1_out", 32'(resp_out), 32'd29);
      check("t1_ovf", 32'(resp_ovf), 32'd0);
      check("t1_id",  32'(resp_id),  32'd0);

      // Both saturated: grants alternate starting with requester 0.
      do_reset();
      for (int k = 0; k < 6; k++) begin
         cycle(1, 8'd0, 8'd1, 1, 8'd127, 8'hFF, 1);
         check("rr_id",  32'(resp_id),  32'(k % 2));
         check("rr_out", 32'(resp_out), (k % 2) ? 32'h80 : 32'hFF);
         check("rr_ovf", 32'(resp_ovf), 32'(k % 2));
      end

      // Overflowing result held under backpressure, then drain + accept.
      do_reset();
      cycle(0, 8'd0, 8'd0, 1, 8'h80, 8'd1, 1);
      for (int k = 0; k < 3; k++) begin
         cycle(1, 8'd5, 8'd3, 1, 8'd7, 8'd2, 0);
         check("bp_out", 32'(resp_out), 32'h7F);
         check("bp_ovf", 32'(resp_ovf), 32'd1);
         check("bp_id",  32'(resp_id),  32'd1);
      end
      cycle(1, 8'd5, 8'd3, 0, 8'd0, 8'd0, 1);
      check("bp_next_out", 32'(resp_out), 32'd2);
      check("bp_next_id",  32'(resp_id),  32'd0);
      check("bp_next_val", 32'(resp_val), 32'd1);

      // Reset in the middle of a held result discards it.
      cycle(1, 8'd9, 8'd4, 0, 8'd0, 8'd0, 0);
      cycle(1, 8'd9, 8'd4, 0, 8'd0, 8'd0, 0);
      #2;
      do_reset();
      cycle(0, 8'd0, 8'd0, 0, 8'd0, 8'd0, 1);
      cycle(0, 8'd0, 8'd0, 1, 8'd13, 8'd42, 1);
      check("pr_out", 32'(resp_out), 32'hE3);
      check("pr_id",  32'(resp_id),  32'd1);
      check("pr_ovf", 32'(resp_ovf), 32'd0);

      // Random traffic until 20 requests are accepted, then drain.
      do_reset();
      acc0   = n_accepted;
      drn0   = n_drained;
      budget = 0;
      while ((n_accepted - acc0) < 20 && budget < 400) begin
         cycle(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
               1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
               1'($urandom_range(0, 3) != 0));
         budget++;
      end
      repeat (3) cycle(0, 8'd0, 8'd0, 0, 8'd0, 8'd0, 1);
      check("rand_accepted", 32'(n_accepted - acc0), 32'd20);
      check("rand_drained",  32'(n_drained - drn0),  32'd20);
      check("rand_left",     32'(m_q.size()),        32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_sub_arb_2req_8b
